// File: rtl/descrambler_ctrl.sv
// Receive-side sequencer for the bit-serial 802.11a descrambler: buffers DATA-field bits,
// feeds them as one unbroken burst, strips SERVICE and emits only the PSDU bits.
module descrambler_ctrl #(
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = 8,
    parameter int LEN_W      = 12
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             LenValid,
    input  logic [LEN_W-1:0] Len,
    input  logic             Abort,
    input  logic             InBit,
    input  logic             InValid,
    output logic             InReady,
    output logic             DsStart,
    output logic             DsX,
    input  logic             DsY,
    output logic             OutBit,
    output logic             OutValid,
    output logic             OutLast,
    output logic             Done,
    output logic             ServiceErr,
    output logic             LenErr,
    output logic             Underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = LEN_W + 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DONE
    } state_t;

    state_t state, stateNext;

    logic [FIFO_DEPTH-1:0] fifoMem;
    logic [AW-1:0]         wrPtr;
    logic [AW-1:0]         rdPtr;
    logic [AW:0]           count;
    logic [LEN_W-1:0]      lenReg;
    logic [CW-1:0]         bitCnt;
    logic [CW-1:0]         totalBits;

    logic fifoEmpty;
    logic fifoFull;
    logic push;
    logic pop;
    logic flush;
    logic lastBit;
    logic startFrame;
    logic underrunNow;

    // Frame length in bits: 16 SERVICE bits followed by 8*Len PSDU bits.
    assign totalBits = CW'(16) + (CW'(lenReg) << 3);
    assign fifoEmpty = (count == '0);
    assign fifoFull  = (count == (AW+1)'(FIFO_DEPTH));
    assign lastBit   = (bitCnt == totalBits - CW'(1));
    assign push      = InValid & InReady;

    // Abort overrides everything else; an empty FIFO mid-burst ends the frame as an underrun.
    always_comb begin
        stateNext   = state;
        InReady     = 1'b0;
        DsStart     = 1'b0;
        DsX         = 1'b0;
        Done        = 1'b0;
        pop         = 1'b0;
        flush       = 1'b0;
        startFrame  = 1'b0;
        underrunNow = 1'b0;
        if (Abort) begin
            stateNext = IDLE;
            flush     = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    flush = 1'b1;
                    if (LenValid && (Len != '0)) begin
                        startFrame = 1'b1;
                        stateNext  = FILL;
                    end
                end
                FILL: begin
                    InReady = !fifoFull;
                    if (count >= (AW+1)'(PREFILL)) begin
                        stateNext = RUN;
                    end
                end
                RUN: begin
                    if (fifoEmpty) begin
                        underrunNow = 1'b1;
                        flush       = 1'b1;
                        stateNext   = IDLE;
                    end else begin
                        pop     = 1'b1;
                        DsStart = 1'b1;
                        DsX     = fifoMem[rdPtr];
                        InReady = 1'b1;
                        if (lastBit) begin
                            stateNext = DONE;
                        end
                    end
                end
                DONE: begin
                    Done      = 1'b1;
                    flush     = 1'b1;
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifoMem[wrPtr] <= InBit;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset || flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // SERVICE bits 0..15 are consumed silently; only 7..15 are checked for the reserved zeros.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            lenReg     <= '0;
            bitCnt     <= '0;
            OutBit     <= 1'b0;
            OutValid   <= 1'b0;
            OutLast    <= 1'b0;
            ServiceErr <= 1'b0;
            LenErr     <= 1'b0;
            Underrun   <= 1'b0;
        end else begin
            state    <= stateNext;
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
            LenErr   <= (state == IDLE) && LenValid && !Abort && (Len == '0);
            if (startFrame) begin
                lenReg     <= Len;
                bitCnt     <= '0;
                ServiceErr <= 1'b0;
                Underrun   <= 1'b0;
            end
            if (underrunNow) begin
                Underrun <= 1'b1;
            end
            if (pop) begin
                bitCnt <= bitCnt + CW'(1);
                if ((bitCnt >= CW'(7)) && (bitCnt <= CW'(15)) && DsY) begin
                    ServiceErr <= 1'b1;
                end
                if (bitCnt >= CW'(16)) begin
                    OutBit   <= DsY;
                    OutValid <= 1'b1;
                    OutLast  <= lastBit;
                end
            end
        end
    end

endmodule

// File: tb/tb_descrambler_ctrl.sv
// Directed bench for descrambler_ctrl: scrambles known frames, models the descrambler
// and compares every emitted PSDU bit against the plaintext.
module tb_descrambler_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        LenValid;
    logic [11:0] Len;
    logic        Abort;
    logic        InBit;
    logic        InValid;
    logic        InReady;
    logic        DsStart;
    logic        DsX;
    logic        DsY;
    logic        OutBit;
    logic        OutValid;
    logic        OutLast;
    logic        Done;
    logic        ServiceErr;
    logic        LenErr;
    logic        Underrun;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    descrambler_ctrl #(.FIFO_DEPTH(16), .PREFILL(8), .LEN_W(12)) dut (
        .Clk(Clk), .Reset(Reset), .LenValid(LenValid), .Len(Len), .Abort(Abort),
        .InBit(InBit), .InValid(InValid), .InReady(InReady), .DsStart(DsStart),
        .DsX(DsX), .DsY(DsY), .OutBit(OutBit), .OutValid(OutValid), .OutLast(OutLast),
        .Done(Done), .ServiceErr(ServiceErr), .LenErr(LenErr), .Underrun(Underrun)
    );

    // Descrambler: loads its state from the first 7 received bits, then runs additively.
    logic [6:0] dsState = 7'd0;
    logic [2:0] dsSync  = 3'd0;
    assign DsY = (dsSync == 3'd7) ? (DsX ^ dsState[6] ^ dsState[3]) : 1'b0;

    always @(posedge Clk) begin
        if (!DsStart) begin
            dsState <= 7'd0;
            dsSync  <= 3'd0;
        end else if (dsSync != 3'd7) begin
            dsState <= {dsState[5:0], DsX};
            dsSync  <= dsSync + 3'd1;
        end else begin
            dsState <= {dsState[5:0], dsState[6] ^ dsState[3]};
        end
    end

    bit frameBits [32776];
    bit dataBits  [32776];
    int nBits;
    int fIdx, outIdx, bitErrs, lastCnt, lastAt, doneCnt, doneLast, popIdx, svcAt8, svcAt9, cyc;
    bit toggleMode;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic buildFrame(input int len, input bit svc9, input bit useA5);
        logic [6:0] s;
        logic [7:0] byteVal;
        bit d, fb;
        s     = 7'b1011101;
        nBits = 16 + 8 * len;
        for (int i = 0; i < nBits; i++) begin
            d = 1'b0;
            if (i >= 16) begin
                byteVal = useA5 ? 8'hA5 : 8'((((i - 16) / 8) * 37 + 11) & 255);
                d       = byteVal[(i - 16) % 8];
            end
            if (svc9 && i == 9) d = 1'b1;
            fb           = s[6] ^ s[3];
            frameBits[i] = d ^ fb;
            dataBits[i]  = d;
            s            = {s[5:0], fb};
        end
    endtask

    task automatic clearStats();
        fIdx = 0; outIdx = 0; bitErrs = 0; lastCnt = 0; lastAt = -1;
        doneCnt = 0; doneLast = 0; popIdx = 0; svcAt8 = -1; svcAt9 = -1;
    endtask

    // One clock: called and returns at a negedge with inputs already driven.
    task automatic tick();
        bit accepted, dsWas;
        int popNum;
        #1;
        accepted = InValid && InReady;
        dsWas    = DsStart;
        popNum   = popIdx;
        @(posedge Clk);
        #1;
        if (accepted) fIdx++;
        if (dsWas) begin
            if (popNum == 8) svcAt8 = ServiceErr;
            if (popNum == 9) svcAt9 = ServiceErr;
            popIdx++;
        end
        if (OutValid) begin
            if (16 + outIdx >= nBits || OutBit != dataBits[16 + outIdx]) bitErrs++;
            outIdx++;
            if (OutLast) begin
                lastCnt++;
                lastAt = outIdx;
            end
        end
        if (Done) begin
            doneCnt++;
            if (OutValid && OutLast) doneLast++;
        end
        @(negedge Clk);
        cyc++;
        InValid = (fIdx < nBits) && (!toggleMode || (cyc % 2 == 0));
        InBit   = InValid ? frameBits[fIdx] : 1'b0;
    endtask

    task automatic applyStimulus(input int len);
        Len      = 12'(len);
        LenValid = 1'b1;
        tick();
        LenValid = 1'b0;
    endtask

    task automatic runFrame(input int maxCycles, input int abortAt, input int resetAt, input int pokeAt);
        bit finished, poked;
        finished = 1'b0;
        poked    = 1'b0;
        for (int c = 0; c < maxCycles && !finished; c++) begin
            if (abortAt >= 0 && outIdx == abortAt) begin
                Abort = 1'b1;
                tick();
                Abort = 1'b0;
                checkOutput("abort_dsstart", DsStart, 0);
                checkOutput("abort_inready", InReady, 0);
                repeat (20) tick();
                finished = 1'b1;
            end else if (resetAt >= 0 && outIdx == resetAt) begin
                Reset = 1'b0;
                tick();
                checkOutput("midrun_reset_outputs",
                            {InReady, DsStart, DsX, OutBit, OutValid, OutLast, Done,
                             ServiceErr, LenErr, Underrun}, 0);
                Reset = 1'b1;
                repeat (3) tick();
                finished = 1'b1;
            end else begin
                if (pokeAt >= 0 && outIdx == pokeAt && !poked) begin
                    Len      = 12'd3;
                    LenValid = 1'b1;
                    poked    = 1'b1;
                end
                tick();
                LenValid = 1'b0;
                if (Underrun) begin
                    checkOutput("underrun_dsstart", DsStart, 0);
                    finished = 1'b1;
                end else if (doneCnt > 0) begin
                    repeat (4) tick();
                    finished = 1'b1;
                end
            end
        end
        if (!finished) checkOutput("timeout", 1, 0);
    endtask

    initial begin
        Reset = 1'b0; LenValid = 1'b0; Len = '0; Abort = 1'b0;
        InBit = 1'b0; InValid = 1'b0; toggleMode = 1'b0; nBits = 0; cyc = 0;
        clearStats();
        @(negedge Clk);
        repeat (3) tick();
        checkOutput("reset_outputs",
                    {InReady, DsStart, DsX, OutBit, OutValid, OutLast, Done,
                     ServiceErr, LenErr, Underrun}, 0);
        Reset = 1'b1;
        tick();

        $display("[TB] Len=1 frame carrying 0xA5");
        buildFrame(1, 1'b0, 1'b1);
        clearStats();
        applyStimulus(1);
        runFrame(300, -1, -1, -1);
        checkOutput("a5_out_count", outIdx, 8);
        checkOutput("a5_bits", bitErrs, 0);
        checkOutput("a5_last_count", lastCnt, 1);
        checkOutput("a5_last_pos", lastAt, 8);
        checkOutput("a5_done_count", doneCnt, 1);
        checkOutput("a5_done_with_last", doneLast, 1);
        checkOutput("a5_service_err", ServiceErr, 0);

        $display("[TB] Len=100 with gapped input");
        buildFrame(100, 1'b0, 1'b0);
        toggleMode = 1'b1;
        clearStats();
        applyStimulus(100);
        runFrame(3000, -1, -1, -1);
        checkOutput("gap_underrun", Underrun, 1);
        checkOutput("gap_done_count", doneCnt, 0);
        checkOutput("gap_last_count", lastCnt, 0);
        toggleMode = 1'b0;

        $display("[TB] Len=100 gap-free, stray LenValid mid-burst");
        clearStats();
        applyStimulus(100);
        runFrame(3000, -1, -1, 50);
        checkOutput("full_out_count", outIdx, 800);
        checkOutput("full_bits", bitErrs, 0);
        checkOutput("full_underrun", Underrun, 0);
        checkOutput("full_done_count", doneCnt, 1);
        checkOutput("full_last_count", lastCnt, 1);

        $display("[TB] SERVICE bit 9 set");
        buildFrame(5, 1'b1, 1'b0);
        clearStats();
        applyStimulus(5);
        runFrame(300, -1, -1, -1);
        checkOutput("svc_err_after_bit8", svcAt8, 0);
        checkOutput("svc_err_after_bit9", svcAt9, 1);
        checkOutput("svc_out_count", outIdx, 40);
        checkOutput("svc_bits", bitErrs, 0);
        checkOutput("svc_done_count", doneCnt, 1);
        checkOutput("svc_err_final", ServiceErr, 1);

        $display("[TB] zero length");
        nBits = 0;
        clearStats();
        applyStimulus(0);
        checkOutput("lenerr_pulse", LenErr, 1);
        checkOutput("lenerr_inready", InReady, 0);
        tick();
        checkOutput("lenerr_clears", LenErr, 0);
        checkOutput("lenerr_inready_later", InReady, 0);

        $display("[TB] abort at PSDU bit 20");
        buildFrame(10, 1'b0, 1'b0);
        clearStats();
        applyStimulus(10);
        runFrame(300, 20, -1, -1);
        checkOutput("abort_out_count", outIdx, 20);
        checkOutput("abort_last_count", lastCnt, 0);
        checkOutput("abort_done_count", doneCnt, 0);
        buildFrame(2, 1'b0, 1'b0);
        clearStats();
        applyStimulus(2);
        runFrame(300, -1, -1, -1);
        checkOutput("post_abort_out_count", outIdx, 16);
        checkOutput("post_abort_bits", bitErrs, 0);
        checkOutput("post_abort_done", doneCnt, 1);

        $display("[TB] reset mid-burst, then Len=4095");
        buildFrame(10, 1'b1, 1'b0);
        clearStats();
        applyStimulus(10);
        runFrame(300, -1, 30, -1);
        buildFrame(4095, 1'b0, 1'b0);
        clearStats();
        applyStimulus(4095);
        runFrame(34000, -1, -1, -1);
        checkOutput("max_out_count", outIdx, 32760);
        checkOutput("max_bits", bitErrs, 0);
        checkOutput("max_done_count", doneCnt, 1);
        checkOutput("max_last_count", lastCnt, 1);
        checkOutput("max_done_with_last", doneLast, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
